// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - registered multi-cycle ALU with start/ready/done handshake and shift-add MUL
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero,
    output logic             overflow
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   count;

    logic             accept;
    logic             is_mul;
    logic             mul_last;
    logic [WIDTH-1:0] acc_next;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic             slt_flag;
    logic             sltu_flag;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign accept   = start && (state != S_MUL);
    assign is_mul   = (ALUControl == OP_MUL);
    assign mul_last = (count == LAST_ITER);
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    assign sum   = a + b;
    assign diff  = a + ~b + 1'b1;
    assign shamt = b[SHW-1:0];
    // Signed compare stays correct when a-b overflows: differing signs decide by a's sign.
    assign slt_flag  = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];
    assign sltu_flag = (a < b);

    // Single-cycle operations; MUL and unused opcodes fall through to zero.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SLL:  alu_res = a << shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_flag};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu_flag};
            OP_XOR:  alu_res = a ^ b;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        ready      = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = is_mul ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                ready = 1'b0;
                if (mul_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (accept) begin
                    state_next = is_mul ? S_MUL : S_DONE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add iteration, and result registers updated only on done-producing edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            ALUResult <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (mul_last) begin
                ALUResult <= acc_next;
                zero      <= (acc_next == '0);
                overflow  <= 1'b0;
            end
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= a;
                mplier <= b;
                acc    <= '0;
                count  <= '0;
            end else begin
                ALUResult <= alu_res;
                zero      <= (alu_res == '0);
                overflow  <= alu_ovf;
            end
        end
    end

endmodule
